// File: rtl/vga_rx_pkg.sv
// Shared timing defaults, FSM encoding and counter helpers for the VGA capture receiver.
// Defaults describe 1280x960 @ 1800x1000 total.
package vga_rx_pkg;

    localparam int CNT_W        = 12;
    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_V_ACTIVE = 960;
    localparam int DEF_H_TOTAL  = 1800;
    localparam int DEF_V_TOTAL  = 1000;
    localparam int DEF_H_START  = 360;
    localparam int DEF_V_START  = 41;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } rx_state_t;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic cnt_t abs_diff(input cnt_t a, input cnt_t b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/vga_capture_rx_sync_edge_detect.sv
// Normalises sync polarity to active-high, registers it once and flags the leading edge.
// The edge pulse is combinational on the registered level, so it is valid in stage 1.
module sync_edge_detect #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk_in,
    input  logic reset,
    input  logic i_sync,
    output logic o_edge
);

    logic r_s1;
    logic r_prev;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_s1   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= ACTIVE_LOW ? ~i_sync : i_sync;
            r_prev <= r_s1;
        end
    end

    assign o_edge = r_s1 & ~r_prev;

endmodule

// File: rtl/vga_capture_rx.sv
// VGA link receiver: rebuilds pixel coordinates from syncs, measures line/frame timing,
// locks once timing is stable and emits qualified pixels. Pins-to-outputs latency is 3 clocks.
module vga_capture_rx
    import vga_rx_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_START     = DEF_H_START,
    parameter int V_START     = DEF_V_START,
    parameter int SYNC_LOW    = 1,
    parameter int LOCK_FRAMES = 4,
    parameter int H_TOL       = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [3:0]  r_in,
    input  logic [3:0]  g_in,
    input  logic [3:0]  b_in,
    output logic        pix_valid,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic [3:0]  pix_r,
    output logic [3:0]  pix_g,
    output logic [3:0]  pix_b,
    output logic        frame_start,
    output logic        locked,
    output logic [11:0] line_period,
    output logic [11:0] frame_lines
);

    localparam cnt_t L_H_BEG = cnt_t'(H_START);
    localparam cnt_t L_H_END = cnt_t'(H_START + H_ACTIVE);
    localparam cnt_t L_V_BEG = cnt_t'(V_START);
    localparam cnt_t L_V_END = cnt_t'(V_START + V_ACTIVE);
    localparam cnt_t L_TOL   = cnt_t'(H_TOL);
    localparam logic [3:0] L_LOCK = 4'(LOCK_FRAMES);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] L_IDLE_MAX = IDLE_W'(TIMEOUT - 1);

    logic w_hedge;
    logic w_vedge;

    sync_edge_detect #(.ACTIVE_LOW(SYNC_LOW != 0)) u_hsync (
        .clk_in (clk_in),
        .reset  (reset),
        .i_sync (h_sync),
        .o_edge (w_hedge)
    );

    sync_edge_detect #(.ACTIVE_LOW(SYNC_LOW != 0)) u_vsync (
        .clk_in (clk_in),
        .reset  (reset),
        .i_sync (v_sync),
        .o_edge (w_vedge)
    );

    logic [11:0]       r_c1, r_c2;
    cnt_t              r_h_raw, r_v_raw, r_line_period, r_frame_lines;
    cnt_t              r_ref_p, r_ref_l;
    logic              r_pend, r_bad;
    logic [IDLE_W-1:0] r_idle;
    logic [3:0]        r_match;
    rx_state_t         r_state;

    cnt_t       w_lp_new, w_fl_new;
    logic       w_frame_end, w_timeout, w_frame_ok, w_line_bad;
    logic [3:0] w_match_inc;
    rx_state_t  w_state_nxt;
    logic [3:0] w_match_nxt;
    logic       w_ref_ld;

    // A frame ends on the first hsync edge at/after a vsync edge.
    assign w_lp_new    = sat_inc(r_h_raw);
    assign w_fl_new    = sat_inc(r_v_raw);
    assign w_frame_end = w_hedge & (r_pend | w_vedge);
    assign w_timeout   = (r_idle == L_IDLE_MAX) & ~w_hedge;
    assign w_line_bad  = abs_diff(w_lp_new, r_ref_p) > L_TOL;
    assign w_frame_ok  = ~r_bad & ~w_line_bad & (w_fl_new == r_ref_l);
    assign w_match_inc = r_match + 4'd1;

    always_ff @(posedge clk_in) begin
        if (reset) r_state <= ST_SEARCH;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match;
        w_ref_ld    = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_vedge && !w_timeout) begin
                    w_state_nxt = ST_MEASURE;
                    w_match_nxt = '0;
                    w_ref_ld    = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (w_timeout) begin
                    w_state_nxt = ST_SEARCH;
                end else if (w_frame_end) begin
                    if (w_frame_ok) begin
                        w_match_nxt = w_match_inc;
                        if (w_match_inc == L_LOCK) w_state_nxt = ST_LOCKED;
                    end else begin
                        w_match_nxt = '0;
                        w_ref_ld    = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_timeout || (w_frame_end && !w_frame_ok)) w_state_nxt = ST_SEARCH;
            end
            default: w_state_nxt = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_c1          <= '0;
            r_c2          <= '0;
            r_h_raw       <= '0;
            r_v_raw       <= '0;
            r_pend        <= 1'b0;
            r_line_period <= '0;
            r_frame_lines <= '0;
            r_idle        <= '0;
            r_match       <= '0;
            r_ref_p       <= '0;
            r_ref_l       <= '0;
            r_bad         <= 1'b0;
        end else begin
            r_c1    <= {r_in, g_in, b_in};
            r_c2    <= r_c1;
            r_match <= w_match_nxt;

            if (w_hedge) begin
                r_h_raw       <= '0;
                r_line_period <= w_lp_new;
            end else begin
                r_h_raw <= sat_inc(r_h_raw);
            end

            if (w_frame_end) begin
                r_frame_lines <= w_fl_new;
                r_v_raw       <= '0;
                r_pend        <= 1'b0;
            end else begin
                if (w_hedge) r_v_raw <= w_fl_new;
                if (w_vedge) r_pend  <= 1'b1;
            end

            if (w_hedge)                  r_idle <= '0;
            else if (r_idle != L_IDLE_MAX) r_idle <= r_idle + 1'b1;

            if (w_ref_ld) begin
                r_ref_p <= w_lp_new;
                r_ref_l <= w_fl_new;
            end

            // Any out-of-tolerance line inside a frame spoils that frame's match.
            if (w_frame_end || w_ref_ld)   r_bad <= 1'b0;
            else if (w_hedge && w_line_bad) r_bad <= 1'b1;
        end
    end

    logic w_valid, w_first;
    cnt_t w_x, w_y;

    assign w_valid = (r_h_raw >= L_H_BEG) && (r_h_raw < L_H_END) &&
                     (r_v_raw >= L_V_BEG) && (r_v_raw < L_V_END) &&
                     (r_state == ST_LOCKED);
    assign w_first = (r_h_raw == L_H_BEG) && (r_v_raw == L_V_BEG);
    assign w_x     = r_h_raw - L_H_BEG;
    assign w_y     = r_v_raw - L_V_BEG;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_r       <= '0;
            pix_g       <= '0;
            pix_b       <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            line_period <= '0;
            frame_lines <= '0;
        end else begin
            pix_valid   <= w_valid;
            pix_x       <= w_valid ? w_x : '0;
            pix_y       <= w_valid ? w_y : '0;
            pix_r       <= w_valid ? r_c2[11:8] : 4'd0;
            pix_g       <= w_valid ? r_c2[7:4]  : 4'd0;
            pix_b       <= w_valid ? r_c2[3:0]  : 4'd0;
            frame_start <= w_valid & w_first;
            locked      <= (r_state == ST_LOCKED);
            line_period <= r_line_period;
            frame_lines <= r_frame_lines;
        end
    end

endmodule
